// File: rtl/serialadd_host.sv
// ---------------------------------------------------------------------------
// serialadd_host
//
// Front end for a bit-serial adder. Accepts a pair of WIDTH-bit unsigned
// operands in parallel, streams them LSB first to the adder as a WIDTH+1 bit
// frame, collects the returned serial sum bits and presents them as a
// parallel WIDTH-bit sum plus carry-out.
//
// Handshakes: both sides use valid/ready. A transfer happens on a rising
// edge where valid=1 and ready=1. A producer holds valid and its data steady
// until that transfer. Ready never depends on valid. Here in_ready is high
// only in IDLE and out_valid only in DONE, so one frame is in flight at a
// time.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_a, in_b          parallel operands (WIDTH bits, unsigned)
//   in_valid, in_ready  operand handshake
//   a, b, sync          serial operand bits and first-bit marker to the adder
//   s                   serial sum bit from the adder, one cycle behind a/b
//   sum, cout           parallel result, (in_a+in_b) mod 2^WIDTH, carry-out
//   out_valid, out_ready result handshake
//   dbg_state           current FSM state (0 IDLE, 1 SEND, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module serialadd_host #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             sync,
    input  logic             s,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  op_a, op_b;   // zero-extended, so bit WIDTH sent as 0
    logic [WIDTH:0]  res;
    logic            capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                op_a <= {1'b0, in_a};
                op_b <= {1'b0, in_b};
                cnt  <= '0;
            end
            // Counter stops at LAST; SEND leaves on that cycle.
            if (state == SEND && cnt != LAST)
                cnt <= cnt + 1'b1;
            // The adder returns bit k one cycle after it was sent, so the
            // shift register fills LSB-first and ends aligned after DRAIN.
            if (capture)
                res <= {s, res[WIDTH:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        sync      = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = SEND;
            end
            SEND: begin
                a       = op_a[cnt];
                b       = op_b[cnt];
                sync    = (cnt == '0);
                // Nothing valid on s yet during the first bit.
                capture = (cnt != '0);
                if (cnt == LAST)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sum       = res[WIDTH-1:0];
    assign cout      = res[WIDTH];
    assign dbg_state = state;

endmodule

// File: tb/tb_serialadd_host.sv
// ---------------------------------------------------------------------------
// tb_serialadd_host
//
// Pairs serialadd_host (WIDTH=8) with a behavioural bit-serial adder and
// checks directed vectors, stall, mid-frame reset and a random stream.
// ---------------------------------------------------------------------------
module tb_serialadd_host;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_a, in_b;
    logic       in_valid, in_ready;
    logic       a, b, sync;
    logic       s = 1'b0;
    logic [7:0] sum;
    logic       cout, out_valid, out_ready;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    serialadd_host #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sync(sync), .s(s),
        .sum(sum), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- bit-serial adder model ----------------
    logic carry = 1'b0;
    always @(posedge clk) begin
        logic cin;
        cin = sync ? 1'b0 : carry;
        s     <= a ^ b ^ cin;
        carry <= (a & b) | (a & cin) | (b & cin);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one directed frame ----------------
    task automatic run_frame(input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] es, input logic ec, input string tag);
        int edges;
        int syncs;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_a = va; in_b = vb; in_valid = 1'b1; out_ready = 1'b1;
        edges = 0; syncs = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            in_valid = 1'b0;
            if (sync) syncs++;
        end while (!out_valid && edges < 40);
        check({tag, " latency"}, 32'(edges), 32'd11);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " sync pulses"}, 32'(syncs), 32'd1);
        check({tag, " in_ready done"}, 32'(in_ready), 32'd0);
        check({tag, " abs done"}, 32'({a, b, sync}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " out_valid after"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- scoreboard for random phase ----------------
    logic [8:0] exp_q[$];
    logic       rnd_on = 1'b0;
    int         got = 0;

    always @(negedge clk) begin
        if (rnd_on) begin
            if (in_valid && in_ready)
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            if (out_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd extra result: got %0h expected none", {cout, sum});
                end else begin
                    check($sformatf("rnd result %0d", got), 32'({cout, sum}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic rnd_driver();
        int w;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            in_a = 8'($urandom_range(0, 255));
            in_b = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!in_ready && w < 200);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] held_sum;
        logic       held_cout;
        int         cyc;
        int         seen;

        vecs[0] = '{8'h01, 8'h01, 8'h02, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[7] = '{8'h0F, 8'hF1, 8'h00, 1'b1};

        reset = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum/cout", 32'({cout, sum}), 32'd0);
        check("reset a/b/sync", 32'({a, b, sync}), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        reset = 1'b0;

        // Table vectors; FF+FF followed directly by 00+00 checks the
        // carry is cleared by the next sync.
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].va, vecs[i].vb, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

        // Stall: result held with out_ready=0.
        @(negedge clk);
        in_a = 8'h3C; in_b = 8'hD4; in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0; cyc++;
        end while (!out_valid && cyc < 40);
        check("stall reached done", 32'(out_valid), 32'd1);
        held_sum = sum; held_cout = cout;
        check("stall sum", 32'({cout, sum}), 32'h110);
        in_valid = 1'b1;  // must be ignored while DONE
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d stable", i), 32'({cout, sum}), 32'({held_cout, held_sum}));
            check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("stall release in_ready", 32'(in_ready), 32'd1);
        check("stall release out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a frame, at SEND bit 4.
        @(negedge clk);
        in_a = 8'hA5; in_b = 8'h5A; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort at bit4 state", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum/cout", 32'({cout, sum}), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no output", 32'(seen), 32'd0);
        run_frame(8'h0F, 8'hF1, 8'h00, 1'b1, "after abort");

        // Random stream with gaps on both sides.
        @(posedge clk); #1;
        out_ready = 1'b0;
        rnd_on = 1'b1;
        fork
            rnd_driver();
        join_none
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rnd result count", 32'(got), 32'd1000);
        check("rnd queue empty", 32'(exp_q.size()), 32'd0);
        rnd_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
